// File: rtl/param_seq_detector.sv
// param_seq_detector: runtime-configurable serial pattern detector with overlap control
// and a saturating match counter.
module param_seq_detector #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(16'b0000_0000_0011_0110),
  parameter int DEF_LEN = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);
  logic [MAX_LEN-1:0] r_hist, r_pat, w_h, w_mask;
  logic [LEN_W-1:0]   r_fill, r_len, w_f, w_len_cl;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovl, r_dout, w_sample, w_match;
  // only the low r_len bits of history and pattern take part in the compare
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign w_mask[i] = 32'(r_len) > i;
  end
  assign w_sample    = en && !cfg_load;
  assign w_h         = {r_hist[MAX_LEN-2:0], din};
  assign w_f         = (r_fill == r_len) ? r_len : r_fill + 1'b1;
  assign w_len_cl    = (32'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
  assign w_match     = w_sample && (r_len != '0) && (w_f == r_len) && (((w_h ^ r_pat) & w_mask) == '0);
  assign dout        = r_dout;
  assign match_count = r_cnt;
  assign count_sat   = &r_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEF_PATTERN;
      r_len  <= LEN_W'(DEF_LEN);
      r_ovl  <= 1'b1;
      r_dout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_dout <= w_match;
      r_cnt  <= clr_count ? CNT_W'(w_match) : r_cnt + CNT_W'(w_match && !count_sat);
      if (cfg_load) begin
        r_pat  <= cfg_pattern;
        r_len  <= w_len_cl;
        r_ovl  <= cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
      end else if (w_sample) begin
        r_hist <= (w_match && !r_ovl) ? '0 : w_h;
        r_fill <= (w_match && !r_ovl) ? '0 : w_f;
      end
    end
  end
endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: directed and randomized checks of param_seq_detector against a
// bit-queue reference model; a second instance with a 2-bit counter covers saturation.
module tb_param_seq_detector;
  logic        clk = 0, reset = 1, en = 0, din = 0, cfg_load = 0, cfg_overlap = 0, clr_count = 0;
  logic [15:0] cfg_pattern = '0;
  logic [4:0]  cfg_len = '0;
  logic        dout, count_sat, dout2, count_sat2;
  logic [7:0]  match_count;
  logic [1:0]  match_count2;
  int          checks = 0, errors = 0;
  bit          run = 0;
  param_seq_detector dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .dout(dout), .match_count(match_count), .count_sat(count_sat)
  );
  param_seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .dout(dout2), .match_count(match_count2), .count_sat(count_sat2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: bits received since the last clear, newest at the back
  logic        q[$];
  logic [15:0] mp;
  int          ml, exp_cnt, exp_cnt2;
  logic        mo, exp_dout, hit;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      mp = 16'b110110; ml = 6; mo = 1; exp_dout = 0; exp_cnt = 0; exp_cnt2 = 0;
    end else begin
      hit = 0;
      if (cfg_load) begin
        mp = cfg_pattern; ml = (cfg_len > 16) ? 16 : int'(cfg_len); mo = cfg_overlap; q.delete();
      end else if (en) begin
        q.push_back(din);
        if (q.size() > 16) void'(q.pop_front());
        if (ml != 0 && q.size() >= ml) begin
          hit = 1;
          for (int k = 0; k < ml; k++) if (q[q.size()-1-k] != mp[k]) hit = 0;
        end
        if (hit && !mo) q.delete();
      end
      exp_dout = hit;
      exp_cnt  = clr_count ? int'(hit) : (hit && exp_cnt < 255) ? exp_cnt + 1 : exp_cnt;
      exp_cnt2 = clr_count ? int'(hit) : (hit && exp_cnt2 < 3) ? exp_cnt2 + 1 : exp_cnt2;
    end
  end
  always @(negedge clk) if (run) begin
    chk("dout", dout, exp_dout);
    chk("count", match_count, exp_cnt);
    chk("sat", count_sat, exp_cnt == 255);
    chk("dout2", dout2, exp_dout);
    chk("count2", match_count2, exp_cnt2);
    chk("sat2", count_sat2, exp_cnt2 == 3);
  end
  task automatic step(input logic e, input logic d);
    en = e; din = d;
    @(posedge clk); #1;
    en = 0; cfg_load = 0; clr_count = 0;
  endtask
  task automatic load(input logic [15:0] p, input logic [4:0] l, input logic o);
    cfg_load = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask
  task automatic stream(input logic [31:0] bits, input int n, output logic [31:0] pulses);
    pulses = '0;
    for (int i = 0; i < n; i++) begin
      step(1, bits[n-1-i]);
      pulses[n-1-i] = dout;
    end
  endtask
  logic [31:0] pl;
  logic [15:0] rp;
  int          sum;
  initial begin
    #1 reset = 0;
    run = 1;
    step(0, 0); step(0, 0);
    chk("rst_dout", dout, 0);
    chk("rst_count", match_count, 0);
    chk("rst_sat", count_sat, 0);
    reset = 1;
    stream(32'b110110110, 9, pl);
    chk("ovl_pulses", pl, 32'b000001001);
    chk("ovl_count", match_count, 2);
    clr_count = 1; step(0, 0);
    load(16'b110110, 6, 0);
    stream(32'b110110110110, 12, pl);
    chk("novl_pulses", pl, 32'b000001000001);
    chk("novl_count", match_count, 2);
    load(16'b101, 3, 1);
    step(1, 1); step(1, 0);
    step(0, 1); step(0, 1); step(0, 1);
    step(1, 1); chk("gap_b3", dout, 1);
    step(1, 0); chk("gap_b4", dout, 0);
    step(1, 1); chk("gap_b5", dout, 1);
    load(16'b101, 3, 1);
    clr_count = 1; step(0, 0);
    stream(32'b1010101, 7, pl);
    chk("sat_pulses", pl, 32'b0010101);
    chk("sat_count2", match_count2, 3);
    chk("sat_flag2", count_sat2, 1);
    step(1, 0); step(1, 1);
    chk("sat_hold2", match_count2, 3);
    chk("sat_big", match_count, 4);
    step(1, 0);
    clr_count = 1; step(1, 1);
    chk("clr_match", match_count, 1);
    chk("clr_match2", match_count2, 1);
    load(16'b110110, 6, 1);
    stream(32'b110110, 6, pl);
    chk("pre_rst_dout", dout, 1);
    chk("pre_rst_count", match_count, 2);
    reset = 0; #1;
    chk("async_dout", dout, 0);
    chk("async_count", match_count, 0);
    chk("async_count2", match_count2, 0);
    step(0, 0);
    reset = 1;
    stream(32'b11011, 5, pl);
    reset = 0; step(0, 0); reset = 1;
    step(1, 0);
    chk("rst_hist_cleared", dout, 0);
    load(16'h1234, 0, 1);
    sum = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      sum += int'(dout);
    end
    step(1, 1); step(1, 1); step(1, 1); step(1, 1);
    sum += int'(dout);
    chk("len0_pulses", sum, 0);
    chk("len0_count", match_count, 0);
    rp = 16'($urandom);
    load(rp, 20, 1);
    stream({16'h0, rp}, 16, pl);
    chk("len16_pulses", pl, 1);
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)
        load(16'($urandom), ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 20)) : 5'($urandom_range(1, 4)),
             1'($urandom_range(0, 1)));
      else if (r < 5) begin
        clr_count = 1; step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 6) begin
        reset = 0; step(1, 1'($urandom_range(0, 1))); reset = 1;
      end else
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
